sm2c_rr_sched: RTL and testbench

SM2C_RR_SCHED -- requirements
Module: sm2c_rr_sched

---
 rtl/sm2c_rr_sched_if.sv | 37 +++
 rtl/sm2c_rr_sched.sv | 115 +++++++++++
 tb/tb_sm2c_rr_sched.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/sm2c_rr_sched_if.sv
// ---------------------------------------------------------------------------
// sm2c_rr_sched_if
// Purpose : bundles the request, grant and result signals of the two-requester
//           sign-magnitude to two's-complement conversion scheduler.
// Signals : req0/sm0, req1/sm1  requests and 4-bit sign-magnitude operands
//           gnt0/gnt1           one-cycle grant pulses
//           y/y_valid/y_src     registered result, valid flag, owner index
//           negzero             operand was 1000
//           y_ack               consumer accepts the result
//           count               results acknowledged since reset
// Modports: slave  - the scheduler side
//           master - the requester/consumer side
// ---------------------------------------------------------------------------
interface sm2c_rr_sched_if;
   logic       req0;
   logic [3:0] sm0;
   logic       req1;
   logic [3:0] sm1;
   logic       gnt0;
   logic       gnt1;
   logic [3:0] y;
   logic       y_valid;
   logic       y_src;
   logic       negzero;
   logic       y_ack;
   logic [7:0] count;

   modport slave (
      input  req0, sm0, req1, sm1, y_ack,
      output gnt0, gnt1, y, y_valid, y_src, negzero, count
   );

   modport master (
      output req0, sm0, req1, sm1, y_ack,
      input  gnt0, gnt1, y, y_valid, y_src, negzero, count
   );
endinterface

// File: rtl/sm2c_rr_sched.sv
// ---------------------------------------------------------------------------
// sm2c_rr_sched
// Purpose : round-robin scheduler for two requesters sharing one
//           sign-magnitude to two's-complement converter. A request is
//           latched in IDLE, granted and converted in CONV, and the result is
//           held in HOLD until the consumer acknowledges it.
// Ports   : clk - rising-edge clock
//           rst - asynchronous active-high reset
//           bus - sm2c_rr_sched_if.slave (requests, grants, result, count)
// ---------------------------------------------------------------------------
module sm2c_rr_sched (
   input  logic               clk,
   input  logic               rst,
   sm2c_rr_sched_if.slave     bus
);

   typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

   state_t     r_state;
   state_t     w_state_next;

   logic       r_ptr;        // requester that wins a tie
   logic       r_win;        // winner of the transaction in flight
   logic [3:0] r_op;         // operand captured on the accepting edge
   logic [3:0] r_y;
   logic       r_y_valid;
   logic       r_y_src;
   logic       r_negzero;
   logic [7:0] r_count;

   logic       w_win;
   logic       w_accept;
   logic       w_done;
   logic       w_gnt0;
   logic       w_gnt1;
   logic [3:0] w_y_conv;
   logic       w_negzero;

   // A sole requester wins outright; on a tie the pointer decides.
   assign w_win = (bus.req0 && bus.req1) ? r_ptr : bus.req1;

   // Negation of the zero-extended magnitude; 1000 naturally folds to 0000.
   assign w_y_conv  = r_op[3] ? (~{1'b0, r_op[2:0]} + 4'd1) : {1'b0, r_op[2:0]};
   assign w_negzero = (r_op == 4'b1000);

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_done       = 1'b0;
      w_gnt0       = 1'b0;
      w_gnt1       = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               w_accept     = 1'b1;
               w_state_next = CONV;
            end
         end
         CONV: begin
            w_gnt0       = ~r_win;
            w_gnt1       = r_win;
            w_state_next = HOLD;
         end
         HOLD: begin
            if (bus.y_ack) begin
               w_done       = 1'b1;
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_ptr     <= 1'b0;
         r_win     <= 1'b0;
         r_op      <= 4'b0000;
         r_y       <= 4'b0000;
         r_y_valid <= 1'b0;
         r_y_src   <= 1'b0;
         r_negzero <= 1'b0;
         r_count   <= 8'd0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_win <= w_win;
            r_op  <= w_win ? bus.sm1 : bus.sm0;
         end
         if (r_state == CONV) begin
            r_y       <= w_y_conv;
            r_y_src   <= r_win;
            r_negzero <= w_negzero;
            r_y_valid <= 1'b1;
         end
         if (w_done) begin
            r_y_valid <= 1'b0;
            r_ptr     <= ~r_y_src;
            r_count   <= r_count + 8'd1;
         end
      end
   end

   // Grants come straight from the state so an asynchronous reset drops them
   // at once.
   assign bus.gnt0    = w_gnt0;
   assign bus.gnt1    = w_gnt1;
   assign bus.y       = r_y;
   assign bus.y_valid = r_y_valid;
   assign bus.y_src   = r_y_src;
   assign bus.negzero = r_negzero;
   assign bus.count   = r_count;

endmodule

// File: tb/tb_sm2c_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_sm2c_rr_sched
// Purpose : self-checking bench for sm2c_rr_sched. Expected results are
//           queued when a request is driven and compared when y_valid rises.
// ---------------------------------------------------------------------------
module tb_sm2c_rr_sched;

   logic clk;
   logic rst;

   sm2c_rr_sched_if bus ();

   sm2c_rr_sched dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_errors;

   // expected entry: {src, negzero, y}
   logic [5:0] sb[$];

   logic       m_ptr;
   logic [7:0] m_count;
   logic       prev_valid;

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference conversion by signed integer arithmetic.
   function automatic logic [3:0] ref_conv(input logic [3:0] s);
      int v;
      v = s[3] ? -int'(s[2:0]) : int'(s[2:0]);
      return v[3:0];
   endfunction

   // Result monitor: one line per completed transaction.
   always @(negedge clk) begin
      if (!rst && bus.y_valid && !prev_valid) begin
         if (sb.size() == 0) begin
            chk_val("sb_empty", 32'd1, 32'd0);
         end else begin
            logic [5:0] e;
            e = sb.pop_front();
            chk_val("y",       {28'd0, bus.y},       {28'd0, e[3:0]});
            chk_val("y_src",   {31'd0, bus.y_src},   {31'd0, e[5]});
            chk_val("negzero", {31'd0, bus.negzero}, {31'd0, e[4]});
            $display("result src=%0d y=%h negzero=%0d count=%0d", bus.y_src, bus.y, bus.negzero, bus.count);
         end
      end
      prev_valid <= bus.y_valid;
   end

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst     = 1'b0;
      m_ptr   = 1'b0;
      m_count = 8'd0;
      sb.delete();
   endtask

   // One full transaction, entered and left at a negedge.
   task automatic issue(input logic r0, input logic [3:0] s0,
                        input logic r1, input logic [3:0] s1,
                        input int hold, input bit disturb);
      logic       win;
      logic [3:0] opv;
      logic [3:0] ey;
      win = (r0 && r1) ? m_ptr : r1;
      opv = win ? s1 : s0;
      ey  = ref_conv(opv);
      sb.push_back({win, (opv == 4'b1000), ey});
      bus.req0 = r0; bus.sm0 = s0;
      bus.req1 = r1; bus.sm1 = s1;
      @(negedge clk);
      chk_val("gnt0_conv", {31'd0, bus.gnt0}, {31'd0, ~win});
      chk_val("gnt1_conv", {31'd0, bus.gnt1}, {31'd0, win});
      chk_val("valid_conv", {31'd0, bus.y_valid}, 32'd0);
      // Operand changes after sampling must not reach the result.
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      bus.sm0 = ~s0;   bus.sm1 = ~s1;
      @(negedge clk);
      chk_val("valid_hold", {31'd0, bus.y_valid}, 32'd1);
      for (int h = 0; h < hold; h++) begin
         if (disturb) begin
            bus.sm0  = 4'($urandom);
            bus.req1 = 1'b1;
         end
         @(negedge clk);
         chk_val("valid_bp", {31'd0, bus.y_valid}, 32'd1);
         chk_val("y_bp", {28'd0, bus.y}, {28'd0, ey});
         chk_val("gnt_bp", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
      end
      bus.req1  = 1'b0;
      bus.y_ack = 1'b1;
      @(negedge clk);
      bus.y_ack = 1'b0;
      m_count   = m_count + 8'd1;
      m_ptr     = ~win;
      chk_val("valid_ack", {31'd0, bus.y_valid}, 32'd0);
      chk_val("count", {24'd0, bus.count}, {24'd0, m_count});
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      prev_valid = 1'b0;
      m_ptr = 1'b0;
      m_count = 8'd0;
      bus.req0 = 1'b0; bus.sm0 = 4'd0;
      bus.req1 = 1'b0; bus.sm1 = 4'd0;
      bus.y_ack = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk_val("rst_y",       {28'd0, bus.y},       32'd0);
      chk_val("rst_valid",   {31'd0, bus.y_valid}, 32'd0);
      chk_val("rst_src",     {31'd0, bus.y_src},   32'd0);
      chk_val("rst_negzero", {31'd0, bus.negzero}, 32'd0);
      chk_val("rst_gnt",     {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
      chk_val("rst_count",   {24'd0, bus.count},   32'd0);
      do_reset();

      // Exhaustive conversion from requester 0.
      for (int i = 0; i < 16; i++) issue(1'b1, 4'(i), 1'b0, 4'd0, 0, 1'b0);
      chk_val("count_16", {24'd0, bus.count}, 32'd16);

      // Tie fairness with y_ack tied high.
      do_reset();
      sb.push_back({1'b0, 1'b0, ref_conv(4'b0011)});
      sb.push_back({1'b1, 1'b0, ref_conv(4'b1010)});
      sb.push_back({1'b0, 1'b0, ref_conv(4'b0011)});
      sb.push_back({1'b1, 1'b0, ref_conv(4'b1010)});
      bus.req0 = 1'b1; bus.sm0 = 4'b0011;
      bus.req1 = 1'b1; bus.sm1 = 4'b1010;
      bus.y_ack = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         chk_val("tie_gnt0", {31'd0, bus.gnt0}, {31'd0, ((c % 3) == 0) && (((c / 3) % 2) == 0)});
         chk_val("tie_gnt1", {31'd0, bus.gnt1}, {31'd0, ((c % 3) == 0) && (((c / 3) % 2) == 1)});
         if (c == 11) begin
            bus.req0 = 1'b0; bus.req1 = 1'b0; bus.y_ack = 1'b0;
         end
      end
      m_count = 8'd4;
      m_ptr   = 1'b0;
      chk_val("tie_count", {24'd0, bus.count}, 32'd4);
      $display("tie sequence count=%0d", bus.count);

      // Backpressure: 10 cycles without ack while sm0 and req1 wiggle.
      issue(1'b1, 4'b0101, 1'b0, 4'd0, 10, 1'b1);
      chk_val("bp_count", {24'd0, bus.count}, 32'd5);

      // Reset between edges while in CONV.
      do_reset();
      bus.req0 = 1'b1; bus.sm0 = 4'b0111;
      @(negedge clk);
      chk_val("mid_gnt0", {31'd0, bus.gnt0}, 32'd1);
      bus.req0 = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk_val("mid_gnt_drop",  {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
      chk_val("mid_valid",     {31'd0, bus.y_valid}, 32'd0);
      chk_val("mid_count",     {24'd0, bus.count}, 32'd0);
      $display("reset during CONV count=%0d", bus.count);
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      m_ptr = 1'b0; m_count = 8'd0;
      issue(1'b0, 4'd0, 1'b1, 4'b1001, 0, 1'b0);

      // Counter wrap over 256 acknowledged conversions.
      do_reset();
      for (int k = 0; k < 256; k++) begin
         issue(1'b1, 4'($urandom), 1'b0, 4'd0, 0, 1'b0);
         if (k == 254) chk_val("count_255", {24'd0, bus.count}, 32'd255);
      end
      chk_val("count_wrap", {24'd0, bus.count}, 32'd0);

      chk_val("sb_drained", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
